// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: lets two requesters share one RAM port. Each access is a
// fixed-length read or write strobe, followed by a one-cycle release before
// the port returns to idle. Under contention the requester that was not
// served last wins. All outputs come straight from registers.
module ram_port_arbiter #(
    parameter int ADDRW         = 8,
    parameter int DATAW         = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             r0_req,
    input  logic             r0_write,
    input  logic [ADDRW-1:0] r0_addr,
    input  logic [DATAW-1:0] r0_wdata,
    output logic             r0_ack,
    output logic [DATAW-1:0] r0_rdata,
    input  logic             r1_req,
    input  logic             r1_write,
    input  logic [ADDRW-1:0] r1_addr,
    input  logic [DATAW-1:0] r1_wdata,
    output logic             r1_ack,
    output logic [DATAW-1:0] r1_rdata,
    output logic [ADDRW-1:0] addressbus,
    output logic [DATAW-1:0] toram,
    input  logic [DATAW-1:0] fromram,
    output logic             read,
    output logic             write,
    output logic             busy,
    output logic             owner
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             own_q, own_d;
    logic             busy_q, busy_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [DATAW-1:0] toram_q, toram_d;
    logic [DATAW-1:0] rdata0_q, rdata0_d;
    logic [DATAW-1:0] rdata1_q, rdata1_d;

    // Winner of a grant at this edge; only meaningful when a request is pending.
    logic win;
    logic win_wr;
    assign win    = (r0_req && r1_req) ? ~last_q : r1_req;
    assign win_wr = win ? r1_write : r0_write;

    // Next-state logic for the IDLE -> ACCESS -> RELEASE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        own_d    = own_q;
        busy_d   = busy_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ack0_d   = ack0_q;
        ack1_d   = ack1_q;
        addr_d   = addr_q;
        toram_d  = toram_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    own_d   = win;
                    busy_d  = 1'b1;
                    cnt_d   = 4'(ACCESS_CYCLES - 1);
                    addr_d  = win ? r1_addr : r0_addr;
                    // Data bus only carries the requester's word on writes.
                    toram_d = win_wr ? (win ? r1_wdata : r0_wdata) : '0;
                    rd_d    = ~win_wr;
                    wr_d    = win_wr;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (rd_q) begin
                        if (own_q) rdata1_d = fromram;
                        else       rdata0_d = fromram;
                    end
                    if (own_q) ack1_d = 1'b1;
                    else       ack0_d = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    toram_d = '0;
                    last_d  = own_q;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RELEASE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                addr_d  = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            own_q    <= 1'b0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            addr_q   <= '0;
            toram_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            own_q    <= own_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            addr_q   <= addr_d;
            toram_q  <= toram_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign addressbus = addr_q;
    assign toram      = toram_q;
    assign read       = rd_q;
    assign write      = wr_q;
    assign busy       = busy_q;
    assign owner      = own_q;
    assign r0_ack     = ack0_q;
    assign r1_ack     = ack1_q;
    assign r0_rdata   = rdata0_q;
    assign r1_rdata   = rdata1_q;
endmodule
